param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_pkg.sv | 17 +
 rtl/param_sync_fifo_ram.sv | 27 ++
 rtl/param_sync_fifo.sv | 134 +++++++++++++
 tb/tb_param_sync_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO: default
// geometry, read-mode encodings and an elaboration helper.
package param_sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 32;

    // Read-mode encodings for the FWFT parameter
    localparam int FWFT_STD  = 0;  // registered read, one cycle latency
    localparam int FWFT_FALL = 1;  // head word visible without a read

    // True when v is a power of two and at least 2
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted write
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO: pointer/count control, status flags,
// sticky error flags and selectable standard or fall-through read data.
//
// Handshake: a write is taken on a rising edge when i_wr_en is high, the
// FIFO is not full and i_clr is low; a read is taken when i_rd_en is high,
// the FIFO is not empty and i_clr is low. Full/empty are judged on the
// occupancy before the edge, so a write into a full FIFO is refused even
// if a read is taken on the same edge. A refused request is not retried.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FWFT       = FWFT_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_rd_en,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_empty,
    output logic                    o_full,
    output logic                    o_almost_empty,
    output logic                    o_almost_full,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject illegal geometry and thresholds at elaboration
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != FWFT_STD && FWFT != FWFT_FALL) begin : g_bad_mode
        $error("param_sync_fifo: FWFT must be 0 or 1");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    // Status flags are pure decodes of the registered occupancy
    assign o_count        = count;
    assign o_empty        = (count == '0);
    assign o_full         = (count == CW'(DEPTH));
    assign o_almost_empty = (count <= CW'(AE_THRESH));
    assign o_almost_full  = (count >= CW'(AF_THRESH));

    assign wr_acc = i_wr_en & ~o_full  & ~i_clr;
    assign rd_acc = i_rd_en & ~o_empty & ~i_clr;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wr_ptr),
        .i_wdata (i_data),
        .i_raddr (rd_ptr),
        .o_rdata (rd_word)
    );

    // Pointers advance on accepted accesses and wrap naturally at DEPTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: simultaneous accepted read and write leave it unchanged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else begin
            count <= count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Sticky error flags, cleared only by reset or flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clr) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr_en && o_full)  o_overflow  <= 1'b1;
            if (i_rd_en && o_empty) o_underflow <= 1'b1;
        end
    end

    if (FWFT == FWFT_FALL) begin : g_fwft
        // Head entry is presented directly; meaningless while empty
        assign o_data = rd_word;
    end else begin : g_std
        // Registered read data, updated only on an accepted read
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                o_data <= '0;
            end else if (rd_acc) begin
                o_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-read and a fall-through instance
// share one stimulus stream and are compared against a queue model.
`timescale 1ns/1ps
module tb_param_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;

    logic [DW-1:0] s_data, f_data;
    logic          s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [3:0]    s_count, f_count;

    int total = 0;
    int bad   = 0;

    param_sync_fifo #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (0),
        .AF_THRESH (AF), .AE_THRESH (AE)
    ) u_std (
        .i_clk (clk), .i_rst_n (rst_n), .i_clr (clr),
        .i_wr_en (wr_en), .i_data (din), .i_rd_en (rd_en),
        .o_data (s_data), .o_empty (s_empty), .o_full (s_full),
        .o_almost_empty (s_ae), .o_almost_full (s_af),
        .o_count (s_count), .o_overflow (s_ovf), .o_underflow (s_udf)
    );

    param_sync_fifo #(
        .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (1),
        .AF_THRESH (AF), .AE_THRESH (AE)
    ) u_fwft (
        .i_clk (clk), .i_rst_n (rst_n), .i_clr (clr),
        .i_wr_en (wr_en), .i_data (din), .i_rd_en (rd_en),
        .o_data (f_data), .o_empty (f_empty), .o_full (f_full),
        .o_almost_empty (f_ae), .o_almost_full (f_af),
        .o_count (f_count), .o_overflow (f_ovf), .o_underflow (f_udf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] mdl_q[$];      // FIFO contents, head at index 0
    logic [DW-1:0] exp_q[$];      // words popped, awaiting registered output
    logic          mdl_ovf, mdl_udf;
    logic [DW-1:0] std_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_q.delete();
            exp_q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else if (clr) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else begin
            automatic bit was_full  = (mdl_q.size() == DEPTH);
            automatic bit was_empty = (mdl_q.size() == 0);
            if (wr_en && was_full)  mdl_ovf = 1'b1;
            if (rd_en && was_empty) mdl_udf = 1'b1;
            if (rd_en && !was_empty) exp_q.push_back(mdl_q.pop_front());
            if (wr_en && !was_full)  mdl_q.push_back(din);
        end
    end

    always @(negedge rst_n) std_hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        automatic int n = mdl_q.size();
        check("s_count", 32'(s_count), 32'(n));
        check("f_count", 32'(f_count), 32'(n));
        check("s_empty", 32'(s_empty), 32'(n == 0));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("s_full",  32'(s_full),  32'(n == DEPTH));
        check("f_full",  32'(f_full),  32'(n == DEPTH));
        check("s_aempty", 32'(s_ae), 32'(n <= AE));
        check("f_aempty", 32'(f_ae), 32'(n <= AE));
        check("s_afull",  32'(s_af), 32'(n >= AF));
        check("f_afull",  32'(f_af), 32'(n >= AF));
        check("s_ovf", 32'(s_ovf), 32'(mdl_ovf));
        check("f_ovf", 32'(f_ovf), 32'(mdl_ovf));
        check("s_udf", 32'(s_udf), 32'(mdl_udf));
        check("f_udf", 32'(f_udf), 32'(mdl_udf));
        if (exp_q.size() > 0) std_hold = exp_q.pop_front();
        check("std_data", 32'(s_data), 32'(std_hold));
        if (n > 0) check("fwft_data", 32'(f_data), 32'(mdl_q[0]));
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        @(negedge clk);
        #1;
        wr_en = w;
        rd_en = r;
        clr   = c;
        din   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs();
        check("rst_s_count", 32'(s_count), 0);
        check("rst_f_count", 32'(f_count), 0);
        check("rst_s_empty", 32'(s_empty), 1);
        check("rst_f_empty", 32'(f_empty), 1);
        check("rst_s_full",  32'(s_full), 0);
        check("rst_s_aempty", 32'(s_ae), 1);
        check("rst_s_afull",  32'(s_af), 0);
        check("rst_s_ovf", 32'(s_ovf), 0);
        check("rst_f_ovf", 32'(f_ovf), 0);
        check("rst_s_udf", 32'(s_udf), 0);
        check("rst_s_data", 32'(s_data), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with 1..8, then a ninth write that must overflow
        for (int i = 1; i <= 9; i++) drive(1'b1, 1'b0, 1'b0, DW'(i));
        idle(1);

        // Drain all eight, then a ninth read that must underflow
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, '0);
        idle(2);

        // Flush, then a lone write into the empty FIFO, read back later
        drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b0, 16'h00AA);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, '0);
        idle(1);

        // Bring occupancy to 4, then 20 cycles of simultaneous read/write
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, DW'($urandom));
        idle(1);

        // Fill up, then simultaneous read/write while full
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
        drive(1'b1, 1'b1, 1'b0, 16'hBEEF);
        idle(2);

        // Flush with a concurrent write: the write is dropped
        drive(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
        drive(1'b1, 1'b1, 1'b1, 16'h1234);
        idle(2);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 3), DW'($urandom));
        end

        // Mid-burst asynchronous reset between edges
        for (int i = 0; i < 12; i++) drive(1'b1, 1'($urandom_range(0, 3) == 0), 1'b0, DW'($urandom));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, DW'($urandom));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, '0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
